dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles waited for bus_ack before abort (used only with DMEM_BRIDGE_TIMEOUT_EN).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_addr  input  32  byte address from the core data port.
REQ-005 cpu_ren  input  1  load request, level, held until cpu_ready.
REQ-006 cpu_wen  input  1  store request, level, held until cpu_ready.
REQ-007 cpu_wdata  input  32  store data, already lane-aligned.
REQ-008 cpu_be  input  4  byte-lane enables for stores.
REQ-009 cpu_rdata  output  32  load data, word-wide, unshifted.
REQ-010 cpu_ready  output  1  memReady to the core; low stalls the pipeline.
REQ-011 bus_req  output  1  bus transaction request.
REQ-012 bus_we  output  1  1 = write, 0 = read.
REQ-013 bus_addr  output  32  word address: cpu_addr[31:2], low bits zero.
REQ-014 bus_wdata  output  32  registered write data.
REQ-015 bus_be  output  4  registered byte enables; 4'b1111 on reads.
REQ-016 bus_ack  input  1  one-cycle completion pulse from the slave.
REQ-017 bus_rdata  input  32  read data, valid with bus_ack.
REQ-018 bus_err  output  1  sticky timeout flag (DMEM_BRIDGE_TIMEOUT_EN only; otherwise tied 0).

Function
REQ-019 FSM states: IDLE, REQ, RESP; IDLE is the reset state.
REQ-020 IDLE: cpu_ready = 1 if neither cpu_ren nor cpu_wen is asserted, else 0 (combinational).
REQ-021 IDLE with cpu_ren or cpu_wen: capture addr, wdata, be, and we (we = cpu_wen); go to REQ next cycle.
REQ-022 cpu_ren and cpu_wen both asserted: treat as a write; the read is dropped.
REQ-023 REQ: bus_req = 1 and bus outputs stable from registers; cpu_ready = 0.
REQ-024 REQ with bus_ack: latch bus_rdata into cpu_rdata on reads (cpu_rdata unchanged on writes); go to RESP.
REQ-025 RESP: cpu_ready = 1 for exactly one cycle, bus_req = 0; go to IDLE unconditionally.
REQ-026 No new request is accepted in RESP, so the held request is never reissued.
REQ-027 Minimum latency: request seen in IDLE at cycle N, bus_req at N+1, ack at N+1 gives cpu_ready at N+2.
REQ-028 bus_ack outside REQ is ignored.
REQ-029 cpu_rdata holds its last value until the next completed read.

Reset
REQ-030 Reset values: FSM in IDLE; bus_req 0; bus_we 0; bus_addr, bus_wdata, cpu_rdata 0; bus_be 0; bus_err 0; timeout counter 0.
REQ-031 Reset asserted in REQ abandons the transaction with no retry; a late bus_ack is ignored (REQ-028).

Configuration
REQ-032 Macro DMEM_BRIDGE_TIMEOUT_EN defined: a counter runs while in REQ and clears on entry to REQ.
REQ-033 With the macro, if the count reaches TIMEOUT_CYCLES without bus_ack:
  - go to RESP;
  - set bus_err (sticky until reset);
  - on reads, load cpu_rdata with 32'hDEADBEEF.
REQ-034 Without the macro: no counter; REQ waits indefinitely; bus_err is constant 0.

Structure
REQ-035 FSM state encoding and the 32'hDEADBEEF constant live in the shared constants header.
REQ-036 The timeout counter is a sub-module, bus_timeout (enable, clear, expired outputs), instantiated only under DMEM_BRIDGE_TIMEOUT_EN.

Verification
REQ-037 Read with ack delay 0: cpu_ren=1, addr=0x104, bus_ack next cycle with rdata 0x11223344 -> bus_addr=0x104, bus_be=4'hF, cpu_ready high at cycle 2, cpu_rdata=0x11223344.
REQ-038 Write with ack after 3 cycles: cpu_wen=1, addr=0x203, be=4'b1000, wdata=0xAB000000 -> bus_addr=0x200, bus_we=1, bus_req held 3 cycles, then one cpu_ready pulse.
REQ-039 Simultaneous ren and wen -> single write transaction; cpu_rdata unchanged.
REQ-040 Back-to-back loads to 0x10 and 0x14 -> two distinct bus transactions; no duplicate for 0x10.
REQ-041 Reset pulsed in REQ, then a stray bus_ack -> state IDLE, cpu_ready=1 with no request, cpu_rdata=0.
REQ-042 Macro defined, TIMEOUT_CYCLES=4, no ack -> RESP after 4 REQ cycles, bus_err=1, cpu_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [31:0] TimeoutRdata = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_bridge_if.sv
// Word-addressed memory bus between the bridge (master) and the memory slave.
interface dmem_bridge_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output we, output addr, output wdata, output be,
                  input ack, input rdata);
  modport slave  (input req, input we, input addr, input wdata, input be,
                  output ack, output rdata);
endinterface

// File: rtl/dmem_bridge_bus_timeout.sv
// Bus wait counter: expires on the TIMEOUT_CYCLES-th enabled cycle after a clear.
module bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Core data port to single-outstanding memory bus bridge.
// Optional bus timeout enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [31:0]   i_cpu_addr,
  input  logic          i_cpu_ren,
  input  logic          i_cpu_wen,
  input  logic [31:0]   i_cpu_wdata,
  input  logic [3:0]    i_cpu_be,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_ready,
  output logic          o_bus_err,
  dmem_bridge_if.master io_bus
);

  state_e      r_state;
  logic        r_bus_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic w_start;
  logic w_expired;
  logic w_unused_addr;

  assign w_start       = (r_state == StIdle) && (i_cpu_ren || i_cpu_wen);
  assign w_unused_addr = ^i_cpu_addr[1:0];

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_enable  (r_state == StReq),
    .i_clear   (w_start),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_bus_req <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            // A simultaneous load+store is issued as the store alone.
            r_state   <= StReq;
            r_bus_req <= 1'b1;
            r_we      <= i_cpu_wen;
            r_addr    <= {i_cpu_addr[31:2], 2'b00};
            r_wdata   <= i_cpu_wdata;
            r_be      <= i_cpu_wen ? i_cpu_be : 4'hF;
          end
        end
        StReq: begin
          if (io_bus.ack) begin
            r_state   <= StResp;
            r_bus_req <= 1'b0;
            if (!r_we) r_rdata <= io_bus.rdata;
          end else if (w_expired) begin
            r_state   <= StResp;
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            if (!r_we) r_rdata <= TimeoutRdata;
          end
        end
        StResp: r_state <= StIdle;
        default: begin
          r_state   <= StIdle;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_ready  = ((r_state == StIdle) && !i_cpu_ren && !i_cpu_wen) || (r_state == StResp);
  assign o_cpu_rdata  = r_rdata;
  assign o_bus_err    = r_bus_err;
  assign io_bus.req   = r_bus_req;
  assign io_bus.we    = r_we;
  assign io_bus.addr  = r_addr;
  assign io_bus.wdata = r_wdata;
  assign io_bus.be    = r_be;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed cases plus randomized transactions.
module tb_dmem_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        bus_err;

  dmem_bridge_if bif ();

  dmem_bridge #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_ren   (cpu_ren),
    .i_cpu_wen   (cpu_wen),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_be    (cpu_be),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ready (cpu_ready),
    .o_bus_err   (bus_err),
    .io_bus      (bif.master)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_txn_exp = 0;
  int          n_txn_obs = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;

  // Completed bus handshakes, counted independently of the stimulus.
  always @(posedge clk) begin
    if (!rst && bif.req && bif.ack) n_txn_obs <= n_txn_obs + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge with the bridge idle.
  task automatic txn(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int delay,
                     input logic [31:0] rd);
    cpu_ren   = ren;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    bif.ack   = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'd0, cpu_ready}, 32'd0);
    for (int k = 0; k <= delay; k++) begin
      @(posedge clk); #1;
      bif.ack   = (k == delay);
      bif.rdata = (k == delay) ? rd : $urandom;
      @(negedge clk);
      check("req_active", {31'd0, bif.req}, 32'd1);
      check("req_ready", {31'd0, cpu_ready}, 32'd0);
      check("req_addr", bif.addr, addr & 32'hFFFF_FFFC);
      check("req_we", {31'd0, bif.we}, {31'd0, wen});
      check("req_be", {28'd0, bif.be}, wen ? {28'd0, be} : 32'hF);
      if (wen) check("req_wdata", bif.wdata, wdata);
    end
    @(posedge clk); #1;
    bif.ack = 1'b0;
    if (!wen) exp_rdata = rd;
    n_txn_exp++;
    @(negedge clk);
    check("resp_ready", {31'd0, cpu_ready}, 32'd1);
    check("resp_req", {31'd0, bif.req}, 32'd0);
    check("resp_rdata", cpu_rdata, exp_rdata);
    check("resp_err", {31'd0, bus_err}, {31'd0, exp_err});
    @(posedge clk); #1;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bif.ack   = ($urandom_range(0, 1) == 1);
      bif.rdata = $urandom;
      @(negedge clk);
      check("idle_ready", {31'd0, cpu_ready}, 32'd1);
      check("idle_req", {31'd0, bif.req}, 32'd0);
      check("idle_rdata", cpu_rdata, exp_rdata);
      @(posedge clk); #1;
    end
    bif.ack = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    bif.ack = 1'b0; bif.rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, cpu_ready}, 32'd1);
    check("rst_req", {31'd0, bif.req}, 32'd0);
    check("rst_we", {31'd0, bif.we}, 32'd0);
    check("rst_addr", bif.addr, 32'd0);
    check("rst_wdata", bif.wdata, 32'd0);
    check("rst_be", {28'd0, bif.be}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;

    txn(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h1122_3344);
    check("rd_fast_data", cpu_rdata, 32'h1122_3344);
    txn(1'b0, 1'b1, 32'h203, 32'hAB00_0000, 4'b1000, 2, 32'h5555_5555);
    txn(1'b1, 1'b1, 32'h300, 32'hCAFE_0001, 4'b0011, 1, 32'h7777_7777);
    check("rw_keeps_rdata", cpu_rdata, 32'h1122_3344);
    idle(2);

    base = n_txn_exp;
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hA0A0_0010);
    txn(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1, 32'hB0B0_0014);
    check("b2b_count", n_txn_obs, base + 2);
    idle(1);

    for (int i = 0; i < 30; i++) begin
      logic ren, wen;
      ren = $urandom_range(0, 1) == 1;
      wen = $urandom_range(0, 1) == 1;
      if (!ren && !wen) ren = 1'b1;
      txn(ren, wen, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 2)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end
    check("txn_count", n_txn_obs, n_txn_exp);

    // Reset during a pending read, then a stray acknowledge.
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h1357_9BDF);
    cpu_ren = 1'b1; cpu_addr = 32'h88;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstreq_active", {31'd0, bif.req}, 32'd1);
    rst = 1'b1; cpu_ren = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bif.ack = 1'b1; bif.rdata = 32'h2468_ACE0;
    exp_rdata = '0;
    @(negedge clk);
    check("rstreq_ready", {31'd0, cpu_ready}, 32'd1);
    check("rstreq_req", {31'd0, bif.req}, 32'd0);
    check("rstreq_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    bif.ack = 1'b0;
    @(negedge clk);
    check("rstreq_rdata2", cpu_rdata, 32'd0);
    check("rstreq_addr", bif.addr, 32'd0);
    @(posedge clk); #1;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    cpu_ren = 1'b1; cpu_addr = 32'h500;
    for (int k = 0; k < int'(TO); k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("to_wait", {31'd0, bif.req}, 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("to_ready", {31'd0, cpu_ready}, 32'd1);
    check("to_err", {31'd0, bus_err}, 32'd1);
    check("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    cpu_ren = 1'b0;
    exp_rdata = 32'hDEAD_BEEF;
    exp_err = 1'b1;
    idle(2);
    check("to_err_sticky", {31'd0, bus_err}, 32'd1);
`else
    txn(1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 40, 32'h0BAD_F00D);
    check("noto_err", {31'd0, bus_err}, 32'd0);
`endif
    check("txn_count_end", n_txn_obs, n_txn_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
